// File: rtl/vga_pkg.sv
// Shared 640x480 @ 60 Hz timing constants and the pixel-coordinate type used
// by the sync generator and the downstream pattern/colour stages.
package vga_pkg;

  localparam int PIX_W = 10;

  localparam int CLK_DIV_640   = 4;
  localparam int H_VISIBLE_640 = 640;
  localparam int H_FRONT_640   = 16;
  localparam int H_SYNC_640    = 96;
  localparam int H_BACK_640    = 48;
  localparam int V_VISIBLE_640 = 480;
  localparam int V_FRONT_640   = 10;
  localparam int V_SYNC_640    = 2;
  localparam int V_BACK_640    = 33;

  localparam int H_TOTAL_640 = H_VISIBLE_640 + H_FRONT_640 + H_SYNC_640 + H_BACK_640;
  localparam int V_TOTAL_640 = V_VISIBLE_640 + V_FRONT_640 + V_SYNC_640 + V_BACK_640;

  typedef logic [PIX_W-1:0] coord_t;

  // Half-open window test: lo <= val < hi.
  function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// System-clock divider producing a one-clk pixel_tick every CLK_DIV cycles.
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pixel_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate horizontal/vertical counters with
// zero-latency combinational decode of syncs, display enable and coordinates.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_640,
  parameter int H_VISIBLE = H_VISIBLE_640,
  parameter int H_FRONT   = H_FRONT_640,
  parameter int H_SYNC    = H_SYNC_640,
  parameter int H_BACK    = H_BACK_640,
  parameter int V_VISIBLE = V_VISIBLE_640,
  parameter int V_FRONT   = V_FRONT_640,
  parameter int V_SYNC    = V_SYNC_640,
  parameter int V_BACK    = V_BACK_640
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pixel_tick,
  output logic             h_sync,
  output logic             v_sync,
  output logic             DE,
  output logic [PIX_W-1:0] x_pixel,
  output logic [PIX_W-1:0] y_pixel,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
  localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  logic   tick;
  logic   h_wrap;
  logic   v_wrap;
  coord_t h_cnt;
  coord_t v_cnt;

  vga_pixel_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick (
    .clk       (clk),
    .reset     (reset),
    .pixel_tick(tick)
  );

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Both counters clear on the same edge at end of frame; reset wins over the
  // tick so a mid-line reset never stretches a sync pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        if (v_wrap) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // NOTE: every output is assigned first in this block so no path leaves a
  // value held, which would otherwise infer a latch.
  always_comb begin
    pixel_tick  = tick;
    h_sync      = 1'b1;
    v_sync      = 1'b1;
    DE          = 1'b0;
    x_pixel     = h_cnt;
    y_pixel     = v_cnt;
    frame_start = 1'b0;

    if (in_window(h_cnt, HS_START, HS_END)) h_sync = 1'b0;
    if (in_window(v_cnt, VS_START, VS_END)) v_sync = 1'b0;
    DE          = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    frame_start = tick && h_wrap && v_wrap;
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance for reset/tick/line
// timing and a scaled-down instance for frame-level vertical behaviour.
module tb_vga_sync_gen;
  import vga_pkg::*;

  localparam int CD = 4;

  // Instance A: 640x480 timing.
  localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
  localparam int A_HT = 800, A_VT = 525;

  // Instance B: small frame so whole frames fit in a short run.
  localparam int B_HV = 20, B_HF = 4, B_HS = 6, B_HB = 2;
  localparam int B_VV = 12, B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int B_HT = 32, B_VT = 19;
  localparam int B_FRAME = B_HT * B_VT * CD;

  typedef struct packed {
    logic             tick;
    logic             hs;
    logic             vs;
    logic             de;
    logic [PIX_W-1:0] x;
    logic [PIX_W-1:0] y;
    logic             fs;
  } obs_t;

  localparam obs_t RESET_OBS = '{tick: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b1,
                                 x: '0, y: '0, fs: 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_a, reset_b;
  logic             pixel_tick_a, h_sync_a, v_sync_a, de_a, frame_start_a;
  logic             pixel_tick_b, h_sync_b, v_sync_b, de_b, frame_start_b;
  logic [PIX_W-1:0] x_pixel_a, y_pixel_a, x_pixel_b, y_pixel_b;

  int n_checks = 0;
  int n_fail   = 0;

  vga_sync_gen #(
    .CLK_DIV(CD), .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB)
  ) dut_a (
    .clk(clk), .reset(reset_a), .pixel_tick(pixel_tick_a), .h_sync(h_sync_a),
    .v_sync(v_sync_a), .DE(de_a), .x_pixel(x_pixel_a), .y_pixel(y_pixel_a),
    .frame_start(frame_start_a)
  );

  vga_sync_gen #(
    .CLK_DIV(CD), .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB)
  ) dut_b (
    .clk(clk), .reset(reset_b), .pixel_tick(pixel_tick_b), .h_sync(h_sync_b),
    .v_sync(v_sync_b), .DE(de_b), .x_pixel(x_pixel_b), .y_pixel(y_pixel_b),
    .frame_start(frame_start_b)
  );

  // Reference: expected outputs after t non-reset edges since the last reset.
  function automatic obs_t model(input longint t, input int hv, input int hf, input int hs,
                                 input int ht, input int vv, input int vf, input int vs,
                                 input int vt);
    obs_t   o;
    longint pix;
    int     dv, h, v;
    pix    = t / CD;
    dv     = int'(t % CD);
    h      = int'(pix % ht);
    v      = int'((pix / ht) % vt);
    o.tick = (dv == CD - 1);
    o.hs   = !((h >= hv + hf) && (h < hv + hf + hs));
    o.vs   = !((v >= vv + vf) && (v < vv + vf + vs));
    o.de   = (h < hv) && (v < vv);
    o.x    = PIX_W'(h);
    o.y    = PIX_W'(v);
    o.fs   = o.tick && (h == ht - 1) && (v == vt - 1);
    return o;
  endfunction

  // Scoreboards: push the expected state at each edge, compare at the next negedge.
  obs_t   q_a[$], q_b[$];
  longint t_a = 0, t_b = 0;
  bit     live_a = 0, live_b = 0;
  int     sb_fail_a = 0, sb_fail_b = 0;

  initial forever begin
    @(posedge clk);
    if (reset_a === 1'b1) begin t_a = 0; live_a = 1; end
    else if (live_a) t_a++;
    if (live_a) q_a.push_back(model(t_a, A_HV, A_HF, A_HS, A_HT, A_VV, A_VF, A_VS, A_VT));
    if (reset_b === 1'b1) begin t_b = 0; live_b = 1; end
    else if (live_b) t_b++;
    if (live_b) q_b.push_back(model(t_b, B_HV, B_HF, B_HS, B_HT, B_VV, B_VF, B_VS, B_VT));
  end

  initial forever begin
    obs_t exp_o, got_o;
    @(negedge clk);
    if (q_a.size() != 0) begin
      exp_o = q_a.pop_front();
      got_o = '{pixel_tick_a, h_sync_a, v_sync_a, de_a, x_pixel_a, y_pixel_a, frame_start_a};
      if (sb_fail_a < 20) begin
        n_checks++;
        if (got_o !== exp_o) begin
          n_fail++; sb_fail_a++;
          $display("FAIL sb_a t=%0d: got %h expected %h", t_a, got_o, exp_o);
        end
      end
    end
    if (q_b.size() != 0) begin
      exp_o = q_b.pop_front();
      got_o = '{pixel_tick_b, h_sync_b, v_sync_b, de_b, x_pixel_b, y_pixel_b, frame_start_b};
      if (sb_fail_b < 20) begin
        n_checks++;
        if (got_o !== exp_o) begin
          n_fail++; sb_fail_b++;
          $display("FAIL sb_b t=%0d: got %h expected %h", t_b, got_o, exp_o);
        end
      end
    end
  end

  task automatic wait_x_a(input int x, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (x_pixel_a == PIX_W'(x)) begin ok = 1; break; end
    end
  endtask

  task automatic wait_xy_b(input int x, input int y, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (x_pixel_b == PIX_W'(x) && y_pixel_b == PIX_W'(y)) begin ok = 1; break; end
    end
  endtask

  task automatic wait_fs_b(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_start_b === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    obs_t got_o;
    reset_a = 1'b1;
    reset_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got_o = '{pixel_tick_a, h_sync_a, v_sync_a, de_a, x_pixel_a, y_pixel_a, frame_start_a};
      n_checks++;
      if (got_o !== RESET_OBS) begin
        n_fail++; $display("FAIL reset_a[%0d]: got %h expected %h", k, got_o, RESET_OBS);
      end
      got_o = '{pixel_tick_b, h_sync_b, v_sync_b, de_b, x_pixel_b, y_pixel_b, frame_start_b};
      n_checks++;
      if (got_o !== RESET_OBS) begin
        n_fail++; $display("FAIL reset_b[%0d]: got %h expected %h", k, got_o, RESET_OBS);
      end
    end
    reset_a = 1'b0;
    reset_b = 1'b0;
  endtask

  // Called at the negedge of release: the state now is what edge 1 will sample.
  task automatic test_tick_spacing();
    int first = -1, prev = -1, bad_gap = 0;
    for (int k = 1; k <= 16; k++) begin
      if (pixel_tick_a === 1'b1) begin
        if (first < 0) first = k;
        else if (k - prev != CD) bad_gap++;
        prev = k;
      end
      @(negedge clk);
    end
    n_checks++;
    if (first != 4) begin n_fail++; $display("FAIL first_tick_edge: got %0d expected 4", first); end
    n_checks++;
    if (bad_gap != 0) begin n_fail++; $display("FAIL tick_gap: got %0d bad gaps expected 0", bad_gap); end
    n_checks++;
    if (x_pixel_a !== PIX_W'(4)) begin
      n_fail++; $display("FAIL x_after_16clk: got %0d expected 4", x_pixel_a);
    end
  endtask

  task automatic test_horizontal();
    bit               ok;
    logic             prev_hs, de_640;
    logic [PIX_W-1:0] prev_x;
    int               fall_x = -1, rise_x = -1, low_clk = 0;
    de_640 = 1'bx;
    wait_x_a(639, 4 * A_HT, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL h_wait_639: got timeout expected x=639"); end
    n_checks++;
    if (de_a !== 1'b1) begin n_fail++; $display("FAIL de_at_639: got %b expected 1", de_a); end
    prev_x  = x_pixel_a;
    prev_hs = h_sync_a;
    for (int i = 0; i < 4 * 130; i++) begin
      @(negedge clk);
      if (prev_x == PIX_W'(639) && x_pixel_a == PIX_W'(640)) de_640 = de_a;
      if (h_sync_a === 1'b0) low_clk++;
      if (prev_hs === 1'b1 && h_sync_a === 1'b0) fall_x = int'(x_pixel_a);
      if (prev_hs === 1'b0 && h_sync_a === 1'b1) rise_x = int'(x_pixel_a);
      prev_x  = x_pixel_a;
      prev_hs = h_sync_a;
    end
    n_checks++;
    if (de_640 !== 1'b0) begin n_fail++; $display("FAIL de_at_640: got %b expected 0", de_640); end
    n_checks++;
    if (fall_x != 656) begin n_fail++; $display("FAIL hsync_fall_x: got %0d expected 656", fall_x); end
    n_checks++;
    if (rise_x != 752) begin n_fail++; $display("FAIL hsync_rise_x: got %0d expected 752", rise_x); end
    n_checks++;
    if (low_clk != 384) begin n_fail++; $display("FAIL hsync_low_clk: got %0d expected 384", low_clk); end
  endtask

  task automatic test_vertical();
    bit ok;
    int vs_low_ticks = 0, vs_bad = 0, de_bad = 0;
    bit in_vs;
    wait_fs_b(2 * B_FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL v_wait_fs: got timeout expected frame_start"); end
    for (int c = 1; c <= B_FRAME; c++) begin
      @(negedge clk);
      in_vs = (y_pixel_b >= PIX_W'(B_VV + B_VF)) && (y_pixel_b < PIX_W'(B_VV + B_VF + B_VS));
      if ((v_sync_b === 1'b0) != in_vs) vs_bad++;
      if (pixel_tick_b === 1'b1 && v_sync_b === 1'b0) vs_low_ticks++;
      if (y_pixel_b >= PIX_W'(B_VV) && de_b !== 1'b0) de_bad++;
    end
    n_checks++;
    if (vs_low_ticks != B_VS * B_HT) begin
      n_fail++; $display("FAIL vsync_low_ticks: got %0d expected %0d", vs_low_ticks, B_VS * B_HT);
    end
    n_checks++;
    if (vs_bad != 0) begin n_fail++; $display("FAIL vsync_window: got %0d bad cycles expected 0", vs_bad); end
    n_checks++;
    if (de_bad != 0) begin n_fail++; $display("FAIL de_blank_lines: got %0d bad cycles expected 0", de_bad); end
  endtask

  task automatic test_frame_wrap();
    bit ok;
    int fs_count = 0, next_fs = -1, de_ticks = 0;
    wait_fs_b(2 * B_FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL f_wait_fs: got timeout expected frame_start"); end
    n_checks++;
    if (x_pixel_b !== PIX_W'(B_HT - 1) || y_pixel_b !== PIX_W'(B_VT - 1)) begin
      n_fail++; $display("FAIL fs_position: got %0d,%0d expected %0d,%0d",
                         x_pixel_b, y_pixel_b, B_HT - 1, B_VT - 1);
    end
    for (int c = 1; c <= B_FRAME; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (x_pixel_b !== '0 || y_pixel_b !== '0 || de_b !== 1'b1) begin
          n_fail++; $display("FAIL wrap_state: got x=%0d y=%0d de=%b expected 0 0 1",
                             x_pixel_b, y_pixel_b, de_b);
        end
      end
      if (frame_start_b === 1'b1) begin
        fs_count++;
        if (next_fs < 0) next_fs = c;
      end
      if (pixel_tick_b === 1'b1 && de_b === 1'b1) de_ticks++;
    end
    n_checks++;
    if (fs_count != 1) begin n_fail++; $display("FAIL fs_count: got %0d expected 1", fs_count); end
    n_checks++;
    if (next_fs != B_FRAME) begin
      n_fail++; $display("FAIL fs_period: got %0d expected %0d", next_fs, B_FRAME);
    end
    n_checks++;
    if (de_ticks != B_HV * B_VV) begin
      n_fail++; $display("FAIL de_ticks: got %0d expected %0d", de_ticks, B_HV * B_VV);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit   ok;
    obs_t got_o;
    int   first;
    // Full-size instance: reset while h_sync is low at x=700.
    wait_x_a(700, 4 * A_HT, ok);
    n_checks++;
    if (!ok || h_sync_a !== 1'b0) begin
      n_fail++; $display("FAIL mid_a_pre: got ok=%0d hs=%b expected ok=1 hs=0", ok, h_sync_a);
    end
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    got_o = '{pixel_tick_a, h_sync_a, v_sync_a, de_a, x_pixel_a, y_pixel_a, frame_start_a};
    n_checks++;
    if (got_o !== RESET_OBS) begin
      n_fail++; $display("FAIL mid_a_post: got %h expected %h", got_o, RESET_OBS);
    end
    // Small instance: reset with both syncs low.
    wait_xy_b(B_HV + B_HF + 2, B_VV + B_VF + 1, 2 * B_FRAME, ok);
    n_checks++;
    if (!ok || h_sync_b !== 1'b0 || v_sync_b !== 1'b0) begin
      n_fail++; $display("FAIL mid_b_pre: got ok=%0d hs=%b vs=%b expected 1 0 0", ok, h_sync_b, v_sync_b);
    end
    reset_b = 1'b1;
    @(negedge clk);
    reset_b = 1'b0;
    got_o = '{pixel_tick_b, h_sync_b, v_sync_b, de_b, x_pixel_b, y_pixel_b, frame_start_b};
    n_checks++;
    if (got_o !== RESET_OBS) begin
      n_fail++; $display("FAIL mid_b_post: got %h expected %h", got_o, RESET_OBS);
    end
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      if (first < 0 && pixel_tick_b === 1'b1) first = k;
      @(negedge clk);
    end
    n_checks++;
    if (first != 4) begin n_fail++; $display("FAIL mid_b_tick_edge: got %0d expected 4", first); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    test_reset();
    test_tick_spacing();
    test_horizontal();
    test_vertical();
    test_frame_wrap();
    test_reset_mid_frame();
    repeat (8) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
